// File: rtl/cordic_pkg.sv
// Shared Q20.44 constants, arbiter state encoding and result payload for the CORDIC arbiter.
package cordic_pkg;

    localparam int unsigned DW = 64;

    typedef logic signed [DW-1:0] q_word_t;

    localparam q_word_t Q_ZERO = 64'sh0000_0000_0000_0000;
    localparam q_word_t Q_ONE  = 64'sh0000_1000_0000_0000;
    localparam q_word_t Q_PI   = 64'sh0000_3243_F6A8_885A;
    localparam q_word_t Q_PI2  = 64'sh0000_6487_ED51_10B4;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_RESP
    } arb_state_t;

    typedef struct packed {
        q_word_t cos_val;
        q_word_t sin_val;
        q_word_t alpha_val;
    } cordic_res_t;

    // Angles outside [0, PI] are rejected without touching the engine.
    function automatic logic ang_out_of_range(input q_word_t a);
        return (a < Q_ZERO) || (a > Q_PI);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set request at or after ptr, wrapping at NR.
module rr_arbiter #(
    parameter int unsigned NR  = 4,
    parameter int unsigned IDW = $clog2(NR)
) (
    input  logic [NR-1:0]  req,
    input  logic [IDW-1:0] ptr,
    output logic [NR-1:0]  gnt,
    output logic [IDW-1:0] gnt_id
);

    logic [NR-1:0] rot;
    logic [IDW-1:0] off;
    logic [IDW:0]   sum;
    logic           found;

    always_comb begin
        rot   = NR'({req, req} >> ptr);
        found = 1'b0;
        off   = '0;
        // Descending scan so the lowest rotated offset wins.
        for (int i = NR - 1; i >= 0; i--) begin
            if (rot[i]) begin
                found = 1'b1;
                off   = IDW'(i);
            end
        end
        sum = (IDW+1)'(ptr) + (IDW+1)'(off);
        if (sum >= (IDW+1)'(NR)) begin
            sum = sum - (IDW+1)'(NR);
        end
        gnt_id = IDW'(sum);
        gnt    = '0;
        if (found) begin
            gnt[gnt_id] = 1'b1;
        end
    end

endmodule

// File: rtl/cordic_arbiter.sv
// Round-robin scheduler sharing one CORDIC engine among NR Goertzel requesters.
// Optional engine watchdog enabled by defining CORDIC_ARB_TIMEOUT_EN.
module cordic_arbiter
    import cordic_pkg::*;
#(
    parameter int unsigned NR      = 4,
    parameter int unsigned IDW     = $clog2(NR),
    parameter int unsigned TMO_CYC = 64
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic [NR-1:0]        req_valid,
    input  logic [NR-1:0][DW-1:0] req_ang,
    output logic [NR-1:0]        req_ready,
    output logic                 eng_start,
    output logic [DW-1:0]        eng_ang,
    input  logic                 eng_done,
    input  logic [DW-1:0]        eng_cos,
    input  logic [DW-1:0]        eng_sin,
    output logic                 rsp_valid,
    output logic [IDW-1:0]       rsp_id,
    output logic [DW-1:0]        rsp_cos,
    output logic [DW-1:0]        rsp_sin,
    output logic [DW-1:0]        rsp_alpha,
    output logic                 rsp_err,
    output logic                 busy
);

    arb_state_t     state_q, state_d;
    logic [IDW-1:0] ptr_q, ptr_d;
    logic [IDW-1:0] id_q, id_d;
    logic [IDW-1:0] rsp_id_q, rsp_id_d;
    q_word_t        ang_q, ang_d;
    logic           rng_err_q, rng_err_d;
    logic           eng_start_q, eng_start_d;
    logic           rsp_valid_q, rsp_valid_d;
    logic           rsp_err_q, rsp_err_d;
    logic           busy_q, busy_d;
    cordic_res_t    res_q, res_d;

    logic [NR-1:0]  gnt;
    logic [IDW-1:0] gnt_id;
    q_word_t        sel_ang;
    logic           sel_bad;
    logic           tmo_hit;

    rr_arbiter #(
        .NR  (NR),
        .IDW (IDW)
    ) u_rr (
        .req    (req_valid),
        .ptr    (ptr_q),
        .gnt    (gnt),
        .gnt_id (gnt_id)
    );

    assign sel_ang = $signed(req_ang[gnt_id]);
    assign sel_bad = ang_out_of_range(sel_ang);

`ifdef CORDIC_ARB_TIMEOUT_EN
    localparam int unsigned TCW = $clog2(TMO_CYC + 1);

    logic [TCW-1:0] tmo_q, tmo_d;

    // Counts cycles spent in WAIT; zero everywhere else so each entry starts fresh.
    always_comb begin
        tmo_d = '0;
        if (state_q == ST_WAIT) begin
            tmo_d = tmo_q + TCW'(1);
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            tmo_q <= '0;
        end else begin
            tmo_q <= tmo_d;
        end
    end

    assign tmo_hit = (tmo_q == TCW'(TMO_CYC - 1));
`else
    assign tmo_hit = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        id_d        = id_q;
        ang_d       = ang_q;
        rng_err_d   = rng_err_q;
        rsp_id_d    = rsp_id_q;
        rsp_err_d   = rsp_err_q;
        res_d       = res_q;
        eng_start_d = 1'b0;
        rsp_valid_d = 1'b0;
        req_ready   = '0;

        case (state_q)
            ST_IDLE: begin
                if (|req_valid) begin
                    req_ready   = gnt;
                    id_d        = gnt_id;
                    ang_d       = sel_ang;
                    rng_err_d   = sel_bad;
                    eng_start_d = !sel_bad;
                    ptr_d       = (gnt_id == IDW'(NR - 1)) ? '0 : gnt_id + IDW'(1);
                    state_d     = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (rng_err_q) begin
                    rsp_valid_d = 1'b1;
                    rsp_id_d    = id_q;
                    rsp_err_d   = 1'b1;
                    res_d       = '0;
                    state_d     = ST_RESP;
                end else begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (eng_done) begin
                    rsp_valid_d     = 1'b1;
                    rsp_id_d        = id_q;
                    rsp_err_d       = 1'b0;
                    res_d.cos_val   = $signed(eng_cos);
                    res_d.sin_val   = $signed(eng_sin);
                    res_d.alpha_val = $signed(eng_cos) <<< 1;
                    state_d         = ST_RESP;
                end else if (tmo_hit) begin
                    rsp_valid_d = 1'b1;
                    rsp_id_d    = id_q;
                    rsp_err_d   = 1'b1;
                    res_d       = '0;
                    state_d     = ST_RESP;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= ST_IDLE;
            ptr_q       <= '0;
            id_q        <= '0;
            ang_q       <= '0;
            rng_err_q   <= 1'b0;
            rsp_id_q    <= '0;
            rsp_err_q   <= 1'b0;
            res_q       <= '0;
            eng_start_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            id_q        <= id_d;
            ang_q       <= ang_d;
            rng_err_q   <= rng_err_d;
            rsp_id_q    <= rsp_id_d;
            rsp_err_q   <= rsp_err_d;
            res_q       <= res_d;
            eng_start_q <= eng_start_d;
            rsp_valid_q <= rsp_valid_d;
            busy_q      <= busy_d;
        end
    end

    assign eng_start = eng_start_q;
    assign eng_ang   = ang_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_cos   = res_q.cos_val;
    assign rsp_sin   = res_q.sin_val;
    assign rsp_alpha = res_q.alpha_val;
    assign rsp_err   = rsp_err_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_cordic_arbiter.sv
// Self-checking bench for cordic_arbiter: directed scenarios plus randomized traffic
// checked against a transaction-level round-robin / timing model.
module tb_cordic_arbiter;
    import cordic_pkg::*;

    localparam int unsigned NR    = 4;
    localparam int unsigned IDW   = 2;
    localparam int unsigned TMO   = 16;
    localparam int          BOUND = 200;

    logic                  clk = 1'b0;
    logic                  rstn;
    logic [NR-1:0]         req_valid;
    logic [NR-1:0][63:0]   req_ang;
    logic [NR-1:0]         req_ready;
    logic                  eng_start;
    logic [63:0]           eng_ang;
    logic                  eng_done;
    logic [63:0]           eng_cos, eng_sin;
    logic                  rsp_valid;
    logic [IDW-1:0]        rsp_id;
    logic [63:0]           rsp_cos, rsp_sin, rsp_alpha;
    logic                  rsp_err;
    logic                  busy;

    int vec_cnt = 0;
    int err_cnt = 0;
    int m_ptr   = 0;

    logic [NR-1:0]  o_gnt;
    int             o_start_cnt, o_start_cyc, o_rsp_cyc;
    logic [63:0]    o_eng_ang, o_cos, o_sin, o_alpha;
    logic [IDW-1:0] o_id;
    logic           o_err;
    bit             o_ang_ok, o_busy_ok;

    always #5 clk = ~clk;

    cordic_arbiter #(
        .NR      (NR),
        .IDW     (IDW),
        .TMO_CYC (TMO)
    ) dut (
        .clk       (clk),
        .rstn      (rstn),
        .req_valid (req_valid),
        .req_ang   (req_ang),
        .req_ready (req_ready),
        .eng_start (eng_start),
        .eng_ang   (eng_ang),
        .eng_done  (eng_done),
        .eng_cos   (eng_cos),
        .eng_sin   (eng_sin),
        .rsp_valid (rsp_valid),
        .rsp_id    (rsp_id),
        .rsp_cos   (rsp_cos),
        .rsp_sin   (rsp_sin),
        .rsp_alpha (rsp_alpha),
        .rsp_err   (rsp_err),
        .busy      (busy)
    );

    function automatic int model_winner(input logic [NR-1:0] v, input int p);
        for (int i = 0; i < NR; i++) begin
            int k;
            k = (p + i) % NR;
            if (v[k]) return k;
        end
        return -1;
    endfunction

    function automatic bit model_in_range(input logic [63:0] a);
        return ($signed(a) >= 0) && ($signed(a) <= $signed(Q_PI));
    endfunction

    function automatic logic [63:0] rnd64();
        return {$urandom, $urandom};
    endfunction

    // Random cosine in [-1.0, 1.0) Q20.44.
    function automatic logic [63:0] rnd_cos();
        logic [63:0] r;
        r = rnd64();
        return 64'($signed(r) >>> 19);
    endfunction

    function automatic logic [63:0] rnd_ang();
        logic [63:0] r;
        logic [63:0] pi_u;
        int          kind;
        r    = rnd64();
        pi_u = Q_PI;
        kind = int'($urandom_range(0, 6));
        case (kind)
            0, 1, 2: return r % (pi_u + 64'd1);
            3:       return pi_u;
            4:       return r | 64'h8000_0000_0000_0000;
            5:       return pi_u + 64'd1 + (r & 64'h0000_0000_FFFF_FFFF);
            default: return 64'd0;
        endcase
    endfunction

    task automatic apply_reset();
        rstn      = 1'b0;
        req_valid = '0;
        eng_done  = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rstn  = 1'b1;
        m_ptr = 0;
    endtask

    // Drives one request round and records what the DUT did; engine answers lat cycles after WAIT entry (lat<0: never).
    task automatic do_txn(input logic [NR-1:0] vld, input logic [NR-1:0][63:0] angs, input int lat,
                          input logic [63:0] cval, input logic [63:0] sval, input bit hold);
        int d_cyc;
        o_gnt = '0; o_start_cnt = 0; o_start_cyc = -1; o_rsp_cyc = -1;
        o_eng_ang = '0; o_cos = '0; o_sin = '0; o_alpha = '0; o_id = '0; o_err = 1'b0;
        o_ang_ok = 1'b1; o_busy_ok = 1'b1;
        d_cyc = -1;
        @(negedge clk);
        req_valid = vld;
        req_ang   = angs;
        #1;
        o_gnt = req_ready;
        if (o_gnt == '0) begin
            req_valid = '0;
            return;
        end
        for (int n = 1; n <= BOUND; n++) begin
            @(negedge clk);
            if (n == 1) req_valid = hold ? vld : '0;
            eng_done = (lat >= 0) && (n == d_cyc);
            eng_cos  = eng_done ? cval : rnd64();
            eng_sin  = eng_done ? sval : rnd64();
            #1;
            if (!busy) o_busy_ok = 1'b0;
            if (eng_start) begin
                o_start_cnt++;
                if (o_start_cyc < 0) begin
                    o_start_cyc = n;
                    o_eng_ang   = eng_ang;
                    if (lat >= 0) d_cyc = n + 1 + lat;
                end
            end
            if (o_start_cyc >= 0 && eng_ang !== o_eng_ang) o_ang_ok = 1'b0;
            if (rsp_valid) begin
                o_rsp_cyc = n; o_id = rsp_id; o_err = rsp_err;
                o_cos = rsp_cos; o_sin = rsp_sin; o_alpha = rsp_alpha;
                break;
            end
        end
        eng_done = 1'b0;
    endtask

    task automatic test_reset();
        logic [NR-1:0] zero_nr;
        zero_nr = '0;
        rstn = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        vec_cnt++; if (req_ready !== zero_nr) begin err_cnt++; $display("FAIL reset_req_ready: got %b want 0", req_ready); end
        vec_cnt++; if (eng_start !== 1'b0) begin err_cnt++; $display("FAIL reset_eng_start: got %b want 0", eng_start); end
        vec_cnt++; if (eng_ang !== 64'd0) begin err_cnt++; $display("FAIL reset_eng_ang: got %h want 0", eng_ang); end
        vec_cnt++; if (rsp_valid !== 1'b0) begin err_cnt++; $display("FAIL reset_rsp_valid: got %b want 0", rsp_valid); end
        vec_cnt++; if (rsp_id !== '0) begin err_cnt++; $display("FAIL reset_rsp_id: got %0d want 0", rsp_id); end
        vec_cnt++; if ({rsp_cos, rsp_sin, rsp_alpha} !== 192'd0) begin err_cnt++; $display("FAIL reset_rsp_data: got %h %h %h want 0", rsp_cos, rsp_sin, rsp_alpha); end
        vec_cnt++; if (rsp_err !== 1'b0) begin err_cnt++; $display("FAIL reset_rsp_err: got %b want 0", rsp_err); end
        vec_cnt++; if (busy !== 1'b0) begin err_cnt++; $display("FAIL reset_busy: got %b want 0", busy); end
        rstn  = 1'b1;
        m_ptr = 0;
    endtask

    task automatic test_single();
        logic [NR-1:0][63:0] angs;
        angs    = '0;
        angs[2] = 64'h0000_0C90_FDAA_2217;
        do_txn(4'b0100, angs, 5, 64'h0000_0B50_4F33_3F9D, 64'h0000_0B50_4F33_3F9D, 1'b0);
        vec_cnt++; if (o_gnt !== 4'b0100) begin err_cnt++; $display("FAIL single_grant: got %b want 0100", o_gnt); end
        vec_cnt++; if (o_start_cyc !== 1 || o_start_cnt !== 1) begin err_cnt++; $display("FAIL single_start: got cyc %0d cnt %0d want 1 1", o_start_cyc, o_start_cnt); end
        vec_cnt++; if (o_eng_ang !== 64'h0000_0C90_FDAA_2217 || !o_ang_ok) begin err_cnt++; $display("FAIL single_eng_ang: got %h stable %0d", o_eng_ang, o_ang_ok); end
        vec_cnt++; if (o_rsp_cyc !== 8) begin err_cnt++; $display("FAIL single_latency: got %0d want 8", o_rsp_cyc); end
        vec_cnt++; if (o_id !== 2'd2 || o_err !== 1'b0) begin err_cnt++; $display("FAIL single_id_err: got %0d %b want 2 0", o_id, o_err); end
        vec_cnt++; if (o_cos !== 64'h0000_0B50_4F33_3F9D || o_sin !== 64'h0000_0B50_4F33_3F9D) begin err_cnt++; $display("FAIL single_cos_sin: got %h %h", o_cos, o_sin); end
        vec_cnt++; if (o_alpha !== 64'h0000_16A0_9E66_7F3A) begin err_cnt++; $display("FAIL single_alpha: got %h want 000016a09e667f3a", o_alpha); end
        @(negedge clk); #1;
        vec_cnt++; if (rsp_valid !== 1'b0 || busy !== 1'b0) begin err_cnt++; $display("FAIL single_one_pulse: got valid %b busy %b want 0 0", rsp_valid, busy); end
        m_ptr = 3;
    endtask

    task automatic test_fairness();
        logic [NR-1:0][63:0] angs;
        logic [NR-1:0]       exp_g;
        apply_reset();
        for (int t = 0; t < 8; t++) begin
            for (int i = 0; i < NR; i++) angs[i] = rnd64() % 64'h0000_3243_F6A8_885A;
            do_txn(4'hF, angs, int'($urandom_range(0, 3)), rnd_cos(), rnd_cos(), t < 7);
            exp_g = '0;
            exp_g[t % NR] = 1'b1;
            vec_cnt++; if (o_gnt !== exp_g || $countones(o_gnt) != 1) begin err_cnt++; $display("FAIL fair_grant[%0d]: got %b want %b", t, o_gnt, exp_g); end
            vec_cnt++; if (o_id !== IDW'(t % NR) || o_rsp_cyc < 0) begin err_cnt++; $display("FAIL fair_rsp_id[%0d]: got %0d cyc %0d want %0d", t, o_id, o_rsp_cyc, t % NR); end
        end
        m_ptr = 0;
    endtask

    task automatic test_range();
        logic [63:0] vals [4];
        bit          exp_ok [4];
        logic [NR-1:0][63:0] angs;
        vals[0] = 64'h0000_4000_0000_0000; exp_ok[0] = 1'b0;
        vals[1] = Q_PI;                     exp_ok[1] = 1'b1;
        vals[2] = Q_PI + 64'sd1;            exp_ok[2] = 1'b0;
        vals[3] = 64'hFFFF_FFFF_FFFF_FFFF;  exp_ok[3] = 1'b0;
        for (int k = 0; k < 4; k++) begin
            angs    = '0;
            angs[1] = vals[k];
            do_txn(4'b0010, angs, 2, 64'h0000_1000_0000_0000, 64'd0, 1'b0);
            vec_cnt++; if (o_gnt !== 4'b0010) begin err_cnt++; $display("FAIL range_grant[%0d]: got %b want 0010", k, o_gnt); end
            vec_cnt++; if (o_start_cnt !== (exp_ok[k] ? 1 : 0)) begin err_cnt++; $display("FAIL range_start[%0d]: got %0d want %0d", k, o_start_cnt, exp_ok[k]); end
            vec_cnt++; if (o_rsp_cyc !== (exp_ok[k] ? 5 : 2)) begin err_cnt++; $display("FAIL range_latency[%0d]: got %0d want %0d", k, o_rsp_cyc, exp_ok[k] ? 5 : 2); end
            vec_cnt++; if (o_err !== !exp_ok[k]) begin err_cnt++; $display("FAIL range_err[%0d]: got %b want %b", k, o_err, !exp_ok[k]); end
            vec_cnt++; if (!exp_ok[k] && {o_cos, o_sin, o_alpha} !== 192'd0) begin err_cnt++; $display("FAIL range_zero[%0d]: got %h %h %h", k, o_cos, o_sin, o_alpha); end
        end
        m_ptr = 2;
    endtask

    task automatic test_stray_done();
        logic [NR-1:0][63:0] angs;
        logic [NR-1:0]       exp_g;
        @(negedge clk);
        req_valid = '0;
        eng_done  = 1'b1;
        eng_cos   = rnd64();
        #1;
        vec_cnt++; if (req_ready !== '0 || busy !== 1'b0) begin err_cnt++; $display("FAIL stray_idle: got ready %b busy %b", req_ready, busy); end
        for (int n = 0; n < 3; n++) begin
            @(negedge clk);
            eng_done = 1'b0;
            #1;
            vec_cnt++; if (rsp_valid !== 1'b0 || busy !== 1'b0 || eng_start !== 1'b0) begin err_cnt++; $display("FAIL stray_quiet[%0d]: got valid %b busy %b start %b", n, rsp_valid, busy, eng_start); end
        end
        angs = '0;
        do_txn(4'hF, angs, 1, 64'd0, 64'd0, 1'b0);
        exp_g = '0;
        exp_g[m_ptr] = 1'b1;
        vec_cnt++; if (o_gnt !== exp_g || o_rsp_cyc !== 4) begin err_cnt++; $display("FAIL stray_after: got %b cyc %0d want %b 4", o_gnt, o_rsp_cyc, exp_g); end
        m_ptr = (m_ptr + 1) % NR;
    endtask

    task automatic test_reset_mid_wait();
        logic [NR-1:0][63:0] angs;
        @(negedge clk);
        req_valid  = 4'b1000;
        req_ang    = '0;
        req_ang[3] = 64'h0000_0100_0000_0000;
        #1;
        vec_cnt++; if (req_ready !== 4'b1000) begin err_cnt++; $display("FAIL rstw_grant: got %b want 1000", req_ready); end
        repeat (3) @(negedge clk);
        req_valid = '0;
        #1;
        vec_cnt++; if (busy !== 1'b1) begin err_cnt++; $display("FAIL rstw_busy: got %b want 1", busy); end
        rstn = 1'b0;
        #1;
        vec_cnt++; if ({eng_start, rsp_valid, rsp_err, busy, req_ready} !== '0 || eng_ang !== 64'd0 || rsp_id !== '0) begin err_cnt++; $display("FAIL rstw_ctrl: got start %b valid %b err %b busy %b ang %h", eng_start, rsp_valid, rsp_err, busy, eng_ang); end
        vec_cnt++; if ({rsp_cos, rsp_sin, rsp_alpha} !== 192'd0) begin err_cnt++; $display("FAIL rstw_data: got %h %h %h want 0", rsp_cos, rsp_sin, rsp_alpha); end
        @(negedge clk);
        rstn     = 1'b1;
        m_ptr    = 0;
        eng_done = 1'b1;
        eng_cos  = 64'h0000_0800_0000_0000;
        @(negedge clk);
        eng_done = 1'b0;
        #1;
        vec_cnt++; if (rsp_valid !== 1'b0 || busy !== 1'b0) begin err_cnt++; $display("FAIL rstw_stale: got valid %b busy %b want 0 0", rsp_valid, busy); end
        angs = '0;
        angs[0] = 64'h0000_0200_0000_0000;
        do_txn(4'b1001, angs, 3, 64'h0000_0F00_0000_0000, 64'h0000_0100_0000_0000, 1'b0);
        vec_cnt++; if (o_gnt !== 4'b0001 || o_rsp_cyc !== 6 || o_alpha !== 64'h0000_1E00_0000_0000) begin err_cnt++; $display("FAIL rstw_next: got %b cyc %0d alpha %h", o_gnt, o_rsp_cyc, o_alpha); end
        m_ptr = 1;
    endtask

`ifdef CORDIC_ARB_TIMEOUT_EN
    task automatic test_timeout();
        logic [NR-1:0][63:0] angs;
        int                  exp_w;
        angs = '0;
        for (int i = 0; i < NR; i++) angs[i] = 64'h0000_0100_0000_0000;
        exp_w = model_winner(4'b0101, m_ptr);
        do_txn(4'b0101, angs, -1, 64'd0, 64'd0, 1'b0);
        vec_cnt++; if (o_rsp_cyc !== 2 + int'(TMO)) begin err_cnt++; $display("FAIL tmo_latency: got %0d want %0d", o_rsp_cyc, 2 + TMO); end
        vec_cnt++; if (o_err !== 1'b1 || {o_cos, o_sin, o_alpha} !== 192'd0 || o_id !== IDW'(exp_w)) begin err_cnt++; $display("FAIL tmo_resp: got err %b id %0d data %h", o_err, o_id, o_cos); end
        @(negedge clk);
        eng_done = 1'b1;
        eng_cos  = 64'h0000_0400_0000_0000;
        #1;
        for (int n = 0; n < 3; n++) begin
            @(negedge clk);
            eng_done = 1'b0;
            #1;
            vec_cnt++; if (rsp_valid !== 1'b0 || busy !== 1'b0) begin err_cnt++; $display("FAIL tmo_late_done[%0d]: got valid %b busy %b", n, rsp_valid, busy); end
        end
        m_ptr = (exp_w + 1) % NR;
    endtask
`endif

    task automatic test_random();
        logic [NR-1:0][63:0] angs;
        logic [NR-1:0]       vld, exp_g;
        logic [63:0]         cval, sval, exp_c, exp_s, exp_a;
        int                  lat, exp_w;
        bit                  ok;
        for (int t = 0; t < 40; t++) begin
            vld = NR'($urandom_range(1, (1 << NR) - 1));
            for (int i = 0; i < NR; i++) angs[i] = rnd_ang();
            lat  = int'($urandom_range(0, 6));
            cval = rnd_cos();
            sval = rnd_cos();
            exp_w = model_winner(vld, m_ptr);
            ok    = model_in_range(angs[exp_w]);
            exp_g = '0;
            exp_g[exp_w] = 1'b1;
            exp_c = ok ? cval : 64'd0;
            exp_s = ok ? sval : 64'd0;
            exp_a = ok ? 64'($signed(cval) * 2) : 64'd0;
            do_txn(vld, angs, lat, cval, sval, 1'($urandom_range(0, 1)));
            vec_cnt++; if (o_gnt !== exp_g) begin err_cnt++; $display("FAIL rnd_grant[%0d]: got %b want %b vld %b", t, o_gnt, exp_g, vld); end
            vec_cnt++; if (o_start_cnt !== (ok ? 1 : 0) || (ok && (o_start_cyc !== 1 || o_eng_ang !== angs[exp_w] || !o_ang_ok))) begin err_cnt++; $display("FAIL rnd_engine[%0d]: got cnt %0d cyc %0d ang %h want ang %h", t, o_start_cnt, o_start_cyc, o_eng_ang, angs[exp_w]); end
            vec_cnt++; if (o_rsp_cyc !== (ok ? 3 + lat : 2) || !o_busy_ok) begin err_cnt++; $display("FAIL rnd_latency[%0d]: got %0d want %0d busy_ok %0d", t, o_rsp_cyc, ok ? 3 + lat : 2, o_busy_ok); end
            vec_cnt++; if (o_id !== IDW'(exp_w) || o_err !== !ok) begin err_cnt++; $display("FAIL rnd_id_err[%0d]: got %0d %b want %0d %b", t, o_id, o_err, exp_w, !ok); end
            vec_cnt++; if (o_cos !== exp_c || o_sin !== exp_s || o_alpha !== exp_a) begin err_cnt++; $display("FAIL rnd_data[%0d]: got %h %h %h want %h %h %h", t, o_cos, o_sin, o_alpha, exp_c, exp_s, exp_a); end
            m_ptr = (exp_w + 1) % NR;
            @(negedge clk);
            req_valid = '0;
            #1;
            vec_cnt++; if (rsp_valid !== 1'b0 || req_ready !== '0) begin err_cnt++; $display("FAIL rnd_idle[%0d]: got valid %b ready %b", t, rsp_valid, req_ready); end
        end
    endtask

    initial begin
        rstn      = 1'b0;
        req_valid = '0;
        req_ang   = '0;
        eng_done  = 1'b0;
        eng_cos   = '0;
        eng_sin   = '0;
        test_reset();
        test_single();
        test_fairness();
        test_range();
        test_stray_done();
        test_reset_mid_wait();
`ifdef CORDIC_ARB_TIMEOUT_EN
        test_timeout();
`endif
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
